// File: rtl/seq_rc_addsub_if.sv
// Start/Busy/Done operand and result bundle between the control unit and the adder.
// master: control unit side, drives Start/Sub/A/B/Cin and observes the results.
// slave: adder side, drives Busy/Done/Result/Cout/Overflow/Zero.
interface seq_rc_addsub_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             Cout;
  logic             Overflow;
  logic             Zero;

  modport master (
    output Start, Sub, A, B, Cin,
    input  Busy, Done, Result, Cout, Overflow, Zero
  );

  modport slave (
    input  Start, Sub, A, B, Cin,
    output Busy, Done, Result, Cout, Overflow, Zero
  );
endinterface

// File: rtl/seq_rc_addsub.sv
// Multi-cycle ripple-carry add/subtract: one CHUNK-bit slice per clock over a WIDTH-bit operand.
// Latency: Done is visible WIDTH/CHUNK edges after the accepted Start; one op per NCHUNK+1 cycles.
// Backpressure: Start is sampled only while idle; Start during Busy is dropped, never queued.
// Ports: clock, clear_n (async active-low); bus (slave) carries Start/Sub/A/B/Cin in,
//   Busy/Done/Result/Cout/Overflow/Zero out. Define SEQ_ADDSUB_SAT_EN to saturate on overflow.
module seq_rc_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clock,
  input  logic          clear_n,
  seq_rc_addsub_if.slave bus
);

  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_rc_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, ovf_q, zero_q, done_q;

  // Slice datapath: operands shift right each RUN cycle so slice k always sits at the bottom.
  logic [CHUNK-1:0] a_s, b_s, sum_s;
  logic             c_out_s, c_msb, ovf_s, last;
  logic [WIDTH-1:0] acc_nxt, res_fin;

  assign a_s = a_q[CHUNK-1:0];
  assign b_s = b_q[CHUNK-1:0];
  assign {c_out_s, sum_s} = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the slice MSB recovered from its sum bit; meaningful for the final slice.
  assign c_msb   = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ sum_s[CHUNK-1];
  assign ovf_s   = c_msb ^ c_out_s;
  assign last    = (k == KW'(NCHUNK - 1));
  // New slice enters at the top; after NCHUNK shifts slice 0 has reached bit 0.
  assign acc_nxt = (acc_q >> CHUNK) | (WIDTH'(sum_s) << (WIDTH - CHUNK));

`ifdef SEQ_ADDSUB_SAT_EN
  // On overflow both operands share A's sign, so A's MSB gives the true result's sign.
  assign res_fin = !ovf_s ? acc_nxt :
                   a_s[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_fin = acc_nxt;
`endif

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.Start) state_nxt = RUN;
      RUN:  if (last)      state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      k        <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.Start) begin
          a_q     <= bus.A;
          b_q     <= bus.Sub ? ~bus.B : bus.B;
          carry_q <= bus.Sub ? 1'b1 : bus.Cin;
          k       <= '0;
        end
      end else begin
        a_q     <= a_q >> CHUNK;
        b_q     <= b_q >> CHUNK;
        carry_q <= c_out_s;
        acc_q   <= acc_nxt;
        k       <= k + KW'(1);
        if (last) begin
          result_q <= res_fin;
          cout_q   <= c_out_s;
          ovf_q    <= ovf_s;
          zero_q   <= (res_fin == '0);
          done_q   <= 1'b1;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    bus.Busy     = (state == RUN);
    bus.Done     = done_q;
    bus.Result   = result_q;
    bus.Cout     = cout_q;
    bus.Overflow = ovf_q;
    bus.Zero     = zero_q;
  end

endmodule

// File: doc/seq_rc_addsub.md
Name: seq_rc_addsub

Overview:
- Parametrised multi-cycle ripple-carry adder/subtractor. It is the next generation of the team's 8-bit combinational RCAdder.
- Processes CHUNK bits per clock, so a wide datapath reuses one narrow ripple slice. Width and throughput trade against each other through parameters.
- Sits in the CPU-G2 ALU path and is driven by the control unit through a Start/Busy/Done handshake.
- Produces the sum or difference plus carry-out, signed overflow and zero flags for the condition-code logic.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be at least 2.
- CHUNK, 8: bits processed per RUN cycle. Must divide WIDTH. NCHUNK = WIDTH/CHUNK. An illegal combination raises an elaboration-time $error.

Ports:
- clock  in  1  single system clock, rising-edge.
- clear_n  in  1  asynchronous active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Sub  in  1  0 = A+B+Cin; 1 = A-B (A+~B+1, Cin ignored). Latched with Start.
- A  in  WIDTH  operand A, latched on the accepted Start.
- B  in  WIDTH  operand B, latched on the accepted Start.
- Cin  in  1  carry-in for add, latched on the accepted Start.
- Busy  out  1  high from the edge after acceptance through the final RUN edge.
- Done  out  1  one-cycle registered pulse; results valid from this cycle until the next Done.
- Result  out  WIDTH  registered sum or difference.
- Cout  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- Overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- Zero  out  1  high when Result == 0, registered with Result.

Behaviour:
- Reset (clear_n=0, asynchronous, any state): state=IDLE, Busy=0, Done=0, Result=0, Cout=0, Overflow=0, Zero=0.
  - Chunk counter, operand registers and the carry register clear.
  - An in-flight operation is discarded with no Done.
- States: IDLE, RUN.
- IDLE, Start=1 at edge E0:
  - Latch A, the effective B (Sub ? ~B : B) and carry = (Sub ? 1 : Cin).
  - Counter=0, go to RUN, Busy=1.
- RUN, edges E1..EN (N = NCHUNK):
  - Add slice [k*CHUNK +: CHUNK] of the operands plus the carry register.
  - Store the slice into an internal accumulator, update carry, increment k.
  - The carry into the MSB is captured during the last slice.
- At edge EN:
  - Result <= accumulator, Cout, Overflow and Zero update.
  - Done <= 1 for exactly one cycle, Busy <= 0, state <= IDLE.
- Latency: Done is visible in the cycle after EN, which is NCHUNK edges after acceptance. CHUNK==WIDTH gives latency 1.
- Result and the flags hold their previous values throughout RUN. They change only at EN or on reset.
- Start while Busy=1 is ignored. Changes to A, B, Sub or Cin during RUN have no effect.
- Back-to-back: Start held high in the Done cycle is accepted at edge EN+1, so throughput is one operation per NCHUNK+1 cycles.
- Arithmetic is modulo 2^WIDTH. No sign extension is applied; signed interpretation affects Overflow only.
- Done never coincides with acceptance of a new Start in the same cycle, because the state is IDLE only after EN.

Optional Feature:
- Macro: SEQ_ADDSUB_SAT_EN.
- When defined:
  - If Overflow would be 1, Result saturates to 0111...1 when the true result is positive (A MSB = 0), or to 1000...0 when negative.
  - Overflow still reports 1 and Cout is unchanged.
  - Zero is computed on the saturated Result.
- When undefined: Result wraps modulo 2^WIDTH and no saturation logic is present.

Test Plan:
- Reset: assert clear_n=0 mid-RUN (after edge E2) -> Busy=0, Done=0, Result=0 and flags=0 immediately; no Done pulse follows. Next Start completes normally.
- Add, defaults: A=42, B=58, Sub=0, Cin=0, Start 1 cycle -> Busy for 4 cycles, Done pulse 4 edges after acceptance, Result=100, Cout=0, Overflow=0, Zero=0.
- Subtract: A=105, B=21, Sub=1 -> Result=84, Cout=1. Then A=21, B=105, Sub=1 -> Result=0xFFFFFFAC, Cout=0, Overflow=0.
- Overflow and wrap:
  - A=0x7FFFFFFF, B=1 -> Result=0x80000000, Overflow=1, Cout=0. With SEQ_ADDSUB_SAT_EN: Result=0x7FFFFFFF.
  - A=0xFFFFFFFF, B=0, Cin=1 -> Result=0, Cout=1, Zero=1, Overflow=0.
- Handshake: change A and pulse Start during Busy -> ignored, Result=first operation. Hold Start high continuously -> Done pulses every 5 cycles, Busy low only in each Done cycle.
- Parameter sweep: WIDTH=8, CHUNK=8 (latency 1) and WIDTH=8, CHUNK=2 (latency 4) -> A=0x2A, B=0x3A gives Result=0x64 in both.
